// File: rtl/sink_arbiter.sv
// rtl/sink_arbiter.sv - round-robin N-to-1 arbiter for 2-phase (toggle) req/ack channels
//
// Shares one transition-signalling sink channel between N transition-signalling
// source channels. A channel is pending while its req differs from its ack.
// One transfer is in flight at a time; the forwarded data is registered.
//
// Ports:
//   clk       rising-edge clock for all state
//   reset     asynchronous active-low reset
//   in_req    per-channel request toggles
//   in_data   channel i data in bits [i*SIZE +: SIZE]
//   in_ack    per-channel acknowledge toggles
//   out_req   sink request, toggles once per forwarded item
//   out_data  registered data to the sink
//   out_ack   sink acknowledge toggle
//   busy      high while a forwarded item awaits out_ack
module sink_arbiter #(
  parameter int ID   = 0,  // instance number, identifies this arbiter in simulation
  parameter int N    = 4,
  parameter int SIZE = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N-1:0]      in_req,
  input  logic [N*SIZE-1:0] in_data,
  output logic [N-1:0]      in_ack,
  output logic              out_req,
  output logic [SIZE-1:0]   out_data,
  input  logic              out_ack,
  output logic              busy
);

  localparam int IW = $clog2(N);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, state_d;
  logic [IW-1:0]   last;
  logic [IW-1:0]   grant;
  logic [IW-1:0]   pick;
  logic [N-1:0]    pending;
  logic            found;
  logic            grant_en;
  logic            done_en;
  logic [SIZE-1:0] chan_data [N];

  assign pending = in_req ^ in_ack;

  for (genvar i = 0; i < N; i++) begin : g_chan
    assign chan_data[i] = in_data[i*SIZE +: SIZE];
  end

  // Search upward from last+1, wrapping, so the channel served last is
  // considered last.
  always_comb begin : rr_search
    logic [IW-1:0] cand;
    found = 1'b0;
    pick  = last;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(last) + k) % N);
      if (!found && pending[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // out_ack == out_req means the sink has consumed the current item. In IDLE
  // out_ack is not looked at, so a stray sink toggle there is ignored.
  always_comb begin : fsm_next
    state_d  = state;
    grant_en = 1'b0;
    done_en  = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          grant_en = 1'b1;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (out_ack == out_req) begin
          done_en = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      last     <= IW'(N - 1);
      grant    <= '0;
      in_ack   <= '0;
      out_req  <= 1'b0;
      out_data <= '0;
      busy     <= 1'b0;
    end else begin
      state <= state_d;
      if (grant_en) begin
        out_data <= chan_data[pick];
        out_req  <= ~out_req;
        grant    <= pick;
        busy     <= 1'b1;
      end
      // in_ack is updated on the way back to IDLE, so the following IDLE
      // cycle already sees the served channel as no longer pending.
      if (done_en) begin
        in_ack[grant] <= ~in_ack[grant];
        last          <= grant;
        busy          <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sink_arbiter.sv
// tb/tb_sink_arbiter.sv - self-checking bench for sink_arbiter
module tb_sink_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  in_req;
  logic [31:0] in_data;
  logic [3:0]  in_ack;
  logic        out_req;
  logic [7:0]  out_data;
  logic        out_ack;
  logic        busy;

  int tests = 0;
  int fails = 0;
  int oreq_toggles;
  logic oreq_prev;

  typedef struct {
    logic [3:0] req;
    logic       ack;
    logic [3:0] e_in_ack;
    logic       e_out_req;
    logic [7:0] e_out_data;
    logic       e_busy;
  } vec_t;

  vec_t tbl[$];

  sink_arbiter #(.ID(0), .N(4), .SIZE(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_req   (in_req),
    .in_data  (in_data),
    .in_ack   (in_ack),
    .out_req  (out_req),
    .out_data (out_data),
    .out_ack  (out_ack),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [3:0] req, input logic ack);
    in_req  = req;
    out_ack = ack;
    @(posedge clk);
    #1;
    if (out_req !== oreq_prev) oreq_toggles++;
    oreq_prev = out_req;
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    in_req  = '0;
    out_ack = 1'b0;
    @(posedge clk);
    #1;
    reset        = 1'b1;
    oreq_prev    = 1'b0;
    oreq_toggles = 0;
  endtask

  task automatic add_vec(input logic [3:0] req, input logic ack, input logic [3:0] ea,
                         input logic eq, input logic [7:0] ed, input logic eb);
    vec_t v;
    v.req = req; v.ack = ack; v.e_in_ack = ea;
    v.e_out_req = eq; v.e_out_data = ed; v.e_busy = eb;
    tbl.push_back(v);
  endtask

  initial begin
    int busy_cycles;
    logic [7:0] d1, d2;
    logic stable;

    reset   = 1'b0;
    in_req  = '0;
    in_data = '0;
    out_ack = 1'b0;

    // Four simultaneous requests, then fairness and in-flight re-toggle.
    // Channel data: ch0=10 ch1=11 ch2=12 ch3=13.
    add_vec(4'hF,0, 4'h0,1,8'h10,1); add_vec(4'hF,0, 4'h0,1,8'h10,1);
    add_vec(4'hF,1, 4'h1,1,8'h10,0); add_vec(4'hF,1, 4'h1,0,8'h11,1);
    add_vec(4'hF,1, 4'h1,0,8'h11,1); add_vec(4'hF,0, 4'h3,0,8'h11,0);
    add_vec(4'hF,0, 4'h3,1,8'h12,1); add_vec(4'hF,0, 4'h3,1,8'h12,1);
    add_vec(4'hF,1, 4'h7,1,8'h12,0); add_vec(4'hF,1, 4'h7,0,8'h13,1);
    add_vec(4'hF,1, 4'h7,0,8'h13,1); add_vec(4'hF,0, 4'hF,0,8'h13,0);
    add_vec(4'hF,0, 4'hF,0,8'h13,0);
    add_vec(4'hD,0, 4'hF,1,8'h11,1); add_vec(4'hD,0, 4'hF,1,8'h11,1);
    add_vec(4'hD,1, 4'hD,1,8'h11,0);
    add_vec(4'hE,1, 4'hD,0,8'h10,1); add_vec(4'hE,1, 4'hD,0,8'h10,1);
    add_vec(4'hE,0, 4'hC,0,8'h10,0); add_vec(4'hE,0, 4'hC,1,8'h11,1);
    add_vec(4'hE,0, 4'hC,1,8'h11,1); add_vec(4'hE,1, 4'hE,1,8'h11,0);
    add_vec(4'h5,1, 4'hE,0,8'h13,1); add_vec(4'h5,1, 4'hE,0,8'h13,1);
    add_vec(4'h5,0, 4'h6,0,8'h13,0); add_vec(4'h5,0, 4'h6,1,8'h10,1);
    add_vec(4'h5,0, 4'h6,1,8'h10,1); add_vec(4'h5,1, 4'h7,1,8'h10,0);
    add_vec(4'h5,1, 4'h7,0,8'h11,1); add_vec(4'h5,1, 4'h7,0,8'h11,1);
    add_vec(4'h5,0, 4'h5,0,8'h11,0); add_vec(4'h5,0, 4'h5,0,8'h11,0);
    add_vec(4'h7,0, 4'h5,1,8'h11,1); add_vec(4'h5,0, 4'h5,1,8'h11,1);
    add_vec(4'h5,1, 4'h7,1,8'h11,0); add_vec(4'h5,1, 4'h7,0,8'h11,1);
    add_vec(4'h5,0, 4'h5,0,8'h11,0); add_vec(4'h5,0, 4'h5,0,8'h11,0);

    // Single request on channel 2
    do_reset();
    check("reset_state", {in_ack, out_req, out_data, busy}, 32'h0);
    in_data = 32'h00A5_0000;
    busy_cycles = 0;
    step(4'b0100, 1'b0);
    if (busy) busy_cycles++;
    check("single_out_req", out_req, 1);
    check("single_out_data", out_data, 8'hA5);
    check("single_in_ack_early", in_ack, 4'h0);
    step(4'b0100, 1'b0);
    if (busy) busy_cycles++;
    step(4'b0100, 1'b1);
    if (busy) busy_cycles++;
    check("single_in_ack", in_ack, 4'h4);
    check("single_busy_cycles", busy_cycles, 2);

    // Table-driven vectors
    do_reset();
    in_data = 32'h1312_1110;
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].req, tbl[i].ack);
      check($sformatf("vec%0d", i + 1), {in_ack, out_req, out_data, busy},
            {tbl[i].e_in_ack, tbl[i].e_out_req, tbl[i].e_out_data, tbl[i].e_busy});
    end

    // Back-to-back items on channel 0
    do_reset();
    in_data = 32'h0000_0001;
    step(4'b0001, 1'b0);
    d1 = out_data;
    step(4'b0001, 1'b0);
    step(4'b0001, 1'b1);
    check("b2b_first_ack", in_ack, 4'h1);
    step(4'b0001, 1'b1);
    in_data = 32'h0000_0002;
    step(4'b0000, 1'b1);
    d2 = out_data;
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    check("b2b_data1", d1, 8'h01);
    check("b2b_data2", d2, 8'h02);
    check("b2b_toggles", oreq_toggles, 2);
    check("b2b_final_ack", in_ack, 4'h0);

    // Slow sink, then a stray out_ack toggle while idle
    do_reset();
    in_data = 32'h0000_5C00;
    step(4'b0010, 1'b0);
    stable = 1'b1;
    repeat (10) begin
      step(4'b0010, 1'b0);
      if (!(out_req === 1'b1 && out_data === 8'h5C && in_ack === 4'h0 && busy === 1'b1))
        stable = 1'b0;
    end
    check("slow_stable", stable, 1);
    step(4'b0010, 1'b1);
    check("slow_done", {in_ack, busy}, {4'h2, 1'b0});
    repeat (3) step(4'b0010, 1'b0);
    check("spurious_ack_idle", {in_ack, out_req, busy}, {4'h2, 1'b1, 1'b0});

    // Reset mid-transfer on channel 3
    do_reset();
    in_data = 32'h7700_0000;
    step(4'b1000, 1'b0);
    check("midrst_busy", {out_req, out_data, busy}, {1'b1, 8'h77, 1'b1});
    #2;
    reset   = 1'b0;
    in_req  = '0;
    out_ack = 1'b0;
    #1;
    check("midrst_async", {in_ack, out_req, out_data, busy}, 32'h0);
    @(posedge clk);
    #1;
    reset     = 1'b1;
    oreq_prev = 1'b0;
    repeat (4) step(4'b0000, 1'b0);
    check("midrst_quiet", {in_ack, out_req, out_data, busy}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
